// File: rtl/vram_display_pkg.sv
// Shared types and helpers for the VRAM scan-out pipeline.
package vram_display_pkg;

    localparam int unsigned PIX_W   = 30;
    localparam int unsigned VRAM_DW = 36;
    localparam int unsigned VRAM_AW = 19;
    localparam int unsigned COORD_W = 12;
    localparam int unsigned SUB_W   = VRAM_DW / 2;

    // Per-clock tag travelling alongside an outstanding VRAM read.
    typedef struct packed {
        logic in_win;
        logic sub_sel;
        logic first;
    } pipe_stage_t;

    // Widen a 6-bit channel to 10 bits by replicating its top bits into the LSBs.
    function automatic logic [9:0] expand6(input logic [5:0] c);
        return {c, c[5:2]};
    endfunction

endpackage

// File: rtl/vram_coord_forecast.sv
// Forecasts raw counters LOOKAHEAD clocks ahead and maps them into signed window coordinates.
module vram_coord_forecast
    import vram_display_pkg::*;
#(
    parameter int unsigned LOOKAHEAD = 4,
    parameter int unsigned H_TOTAL   = 1344,
    parameter int unsigned V_TOTAL   = 806,
    parameter int unsigned XOFFSET   = 0,
    parameter int unsigned YOFFSET   = 0,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480
) (
    input  logic [10:0]                hcount,
    input  logic [9:0]                 vcount,
    output logic signed [COORD_W-1:0]  fx_c,
    output logic signed [COORD_W-1:0]  fy_c,
    output logic                       in_win_c
);

    logic [COORD_W-1:0] h_sum;
    logic [COORD_W-1:0] hf;
    logic [COORD_W-1:0] vf;

    assign h_sum = COORD_W'(hcount) + COORD_W'(LOOKAHEAD);

    // Wrap the horizontal forecast into the next line, and the line into the next frame.
    always_comb begin
        hf = h_sum;
        vf = COORD_W'(vcount);
        if (h_sum >= COORD_W'(H_TOTAL)) begin
            hf = h_sum - COORD_W'(H_TOTAL);
            vf = COORD_W'(vcount) + COORD_W'(1);
            if (vf >= COORD_W'(V_TOTAL)) begin
                vf = '0;
            end
        end
    end

    assign fx_c = $signed(hf - COORD_W'(XOFFSET));
    assign fy_c = $signed(vf - COORD_W'(YOFFSET));

    // Negative coordinates are outside; no modular aliasing onto the far edge.
    assign in_win_c = !fx_c[COORD_W-1] && !fy_c[COORD_W-1] &&
                      ($unsigned(fx_c) < COORD_W'(H_ACTIVE)) &&
                      ($unsigned(fy_c) < COORD_W'(V_ACTIVE));

endmodule

// File: rtl/vram_display_pipe.sv
// VRAM scan-out: forecast, read issue, realignment, unpack, upscale, border fill.
// Optional test-pattern generator enabled by defining VRAM_DISPLAY_PIPE_TPG_EN.
module vram_display_pipe
    import vram_display_pkg::*;
#(
    parameter int unsigned XOFFSET      = 0,
    parameter int unsigned YOFFSET      = 0,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned H_TOTAL      = 1344,
    parameter int unsigned V_TOTAL      = 806,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned PIX_PER_WORD = 1,
    parameter int unsigned SCALE_SHIFT  = 0,
    parameter int unsigned X_ADDR_BITS  = 10,
    parameter logic [PIX_W-1:0] BORDER_COLOR = 30'h0808_0200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [10:0]         hcount,
    input  logic [9:0]          vcount,
    output logic [VRAM_AW-1:0]  vram_addr,
    input  logic [VRAM_DW-1:0]  vram_read_data,
`ifdef VRAM_DISPLAY_PIPE_TPG_EN
    input  logic                tpg_on,
`endif
    output logic [PIX_W-1:0]    vr_pixel,
    output logic                pix_in_window,
    output logic                frame_start
);

    localparam int unsigned LOOKAHEAD = RD_LATENCY + 2;
    localparam int unsigned DEPTH     = LOOKAHEAD - 1;

    // Reject unsupported configurations at elaboration.
    if (!(PIX_PER_WORD == 1 || PIX_PER_WORD == 2)) begin : g_bad_ppw
        $error("vram_display_pipe: PIX_PER_WORD must be 1 or 2");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("vram_display_pipe: RD_LATENCY must be 1..4");
    end
    if (SCALE_SHIFT > 2) begin : g_bad_scale
        $error("vram_display_pipe: SCALE_SHIFT must be 0..2");
    end

    logic signed [COORD_W-1:0] fx;
    logic signed [COORD_W-1:0] fy;
    logic                      in_win_c;
    logic [COORD_W-1:0]        sx;
    logic [COORD_W-1:0]        sy;
    logic [COORD_W-1:0]        word_col;
    logic [VRAM_AW-1:0]        addr_next;
    pipe_stage_t               stage_in;
    pipe_stage_t               pipe [DEPTH];
    pipe_stage_t               tail;
    logic [SUB_W-1:0]          half;
    logic [PIX_W-1:0]          pix_vram;
    logic [PIX_W-1:0]          pix_c;

    vram_coord_forecast #(
        .LOOKAHEAD (LOOKAHEAD),
        .H_TOTAL   (H_TOTAL),
        .V_TOTAL   (V_TOTAL),
        .XOFFSET   (XOFFSET),
        .YOFFSET   (YOFFSET),
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE)
    ) u_forecast (
        .hcount   (hcount),
        .vcount   (vcount),
        .fx_c     (fx),
        .fy_c     (fy),
        .in_win_c (in_win_c)
    );

    // Upscaling divides window coordinates down to source pixels, then to word columns.
    assign sx        = $unsigned(fx) >> SCALE_SHIFT;
    assign sy        = $unsigned(fy) >> SCALE_SHIFT;
    assign word_col  = (PIX_PER_WORD == 2) ? (sx >> 1) : sx;
    assign addr_next = (VRAM_AW'(sy) << X_ADDR_BITS) | VRAM_AW'(word_col);

    assign stage_in = '{
        in_win:  in_win_c,
        sub_sel: (PIX_PER_WORD == 2) ? sx[0] : 1'b0,
        first:   (fx == '0) && (fy == '0)
    };

    // Issue a read only for in-window forecasts; otherwise hold the last address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_addr <= '0;
        end else if (in_win_c) begin
            vram_addr <= addr_next;
        end
    end

    // Tag shift register matching the address-to-data latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '{default: '0};
        end else begin
            pipe[0] <= stage_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[DEPTH-1];

    // Pick the pixel out of the returned word.
    always_comb begin
        half = tail.sub_sel ? vram_read_data[VRAM_DW-1:SUB_W] : vram_read_data[SUB_W-1:0];
        if (PIX_PER_WORD == 1) begin
            pix_vram = vram_read_data[PIX_W-1:0];
        end else begin
            pix_vram = {expand6(half[17:12]), expand6(half[11:6]), expand6(half[5:0])};
        end
    end

`ifdef VRAM_DISPLAY_PIPE_TPG_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_c;
    logic [2:0] bar_pipe [DEPTH];
    logic [2:0] bar;

    assign bar_c = 3'($unsigned(fx) / COORD_W'(BAR_W));
    assign bar   = bar_pipe[DEPTH-1];

    // Bar index rides alongside the read so it lines up with the output pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_pipe <= '{default: '0};
        end else begin
            bar_pipe[0] <= bar_c;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
        end
    end

    assign pix_c = tpg_on ? {{10{bar[2]}}, {10{bar[1]}}, {10{bar[0]}}} : pix_vram;
`else
    assign pix_c = pix_vram;
`endif

    // Registered pixel, window flag and frame marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vr_pixel      <= BORDER_COLOR;
            pix_in_window <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            vr_pixel      <= tail.in_win ? pix_c : BORDER_COLOR;
            pix_in_window <= tail.in_win;
            frame_start   <= tail.first;
        end
    end

endmodule

// File: tb/tb_vram_display_pipe.sv
// Randomised scan-out bench: three configurations against a position-based reference model.
module tb_vram_display_pipe;

    localparam int HT = 1344;
    localparam int VT = 806;
    localparam logic [29:0] BORDER = 30'h0808_0200;

    typedef struct {
        int xoff; int yoff; int ha; int va; int ppw; int s; int xab; int rd;
    } cfg_t;

    typedef struct {
        int h; int v; bit ok;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;

    logic [18:0] addr_o [3];
    logic [35:0] rdata  [3];
    logic [29:0] pix_o  [3];
    logic        win_o  [3];
    logic        fs_o   [3];

    logic [18:0] dl0 [2] = '{19'd0, 19'd0};
    logic [18:0] dl1 [3] = '{19'd0, 19'd0, 19'd0};
    logic [18:0] dl2 = 19'd0;

    cfg_t        cfg [3];
    logic [18:0] exp_addr [3];
    ent_t        hist [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          fs_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [35:0] mem_word(input logic [18:0] a);
        return {a[16:0], a};
    endfunction

    vram_display_pipe u0 (
        .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
        .vram_addr(addr_o[0]), .vram_read_data(rdata[0]),
`ifdef VRAM_DISPLAY_PIPE_TPG_EN
        .tpg_on(1'b0),
`endif
        .vr_pixel(pix_o[0]), .pix_in_window(win_o[0]), .frame_start(fs_o[0])
    );

    vram_display_pipe #(
        .XOFFSET(100), .YOFFSET(20), .H_ACTIVE(320), .V_ACTIVE(200),
        .RD_LATENCY(3), .PIX_PER_WORD(2), .SCALE_SHIFT(1)
    ) u1 (
        .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
        .vram_addr(addr_o[1]), .vram_read_data(rdata[1]),
`ifdef VRAM_DISPLAY_PIPE_TPG_EN
        .tpg_on(1'b0),
`endif
        .vr_pixel(pix_o[1]), .pix_in_window(win_o[1]), .frame_start(fs_o[1])
    );

    vram_display_pipe #(
        .XOFFSET(8), .YOFFSET(3), .H_ACTIVE(64), .V_ACTIVE(16),
        .RD_LATENCY(1), .PIX_PER_WORD(1), .SCALE_SHIFT(2), .X_ADDR_BITS(6)
    ) u2 (
        .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
        .vram_addr(addr_o[2]), .vram_read_data(rdata[2]),
`ifdef VRAM_DISPLAY_PIPE_TPG_EN
        .tpg_on(1'b0),
`endif
        .vr_pixel(pix_o[2]), .pix_in_window(win_o[2]), .frame_start(fs_o[2])
    );

    // VRAM models: data appears RD_LATENCY clocks after the address.
    always @(posedge clk) begin
        dl0[0] <= addr_o[0];
        dl0[1] <= dl0[0];
        dl1[0] <= addr_o[1];
        dl1[1] <= dl1[0];
        dl1[2] <= dl1[1];
        dl2    <= addr_o[2];
    end

    assign rdata[0] = mem_word(dl0[1]);
    assign rdata[1] = mem_word(dl1[2]);
    assign rdata[2] = mem_word(dl2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Position K clocks ahead on the linear raster.
    function automatic void fcast(input int h, input int v, input int k, output int hf, output int vf);
        int p;
        p  = (v * HT + h + k) % (HT * VT);
        hf = p % HT;
        vf = p / HT;
    endfunction

    function automatic logic [9:0] widen(input logic [5:0] c6);
        int c;
        c = int'(c6);
        return 10'(c * 16 + c / 4);
    endfunction

    // What the screen should show at raster position (hf, vf) for a configuration.
    function automatic void model(input cfg_t c, input int hf, input int vf,
                                  output bit w, output bit first,
                                  output logic [18:0] a, output logic [29:0] p);
        int x, y, sx, sy, word;
        logic [35:0] d;
        logic [17:0] hw;
        x = hf - c.xoff;
        y = vf - c.yoff;
        w = (x >= 0) && (x < c.ha) && (y >= 0) && (y < c.va);
        first = w && (x == 0) && (y == 0);
        a = '0;
        p = BORDER;
        if (w) begin
            sx   = x / (1 << c.s);
            sy   = y / (1 << c.s);
            word = sx / c.ppw;
            a    = 19'((sy * (1 << c.xab) + word) % (1 << 19));
            d    = mem_word(a);
            if (c.ppw == 1) begin
                p = d[29:0];
            end else begin
                hw = (sx % 2 == 0) ? d[17:0] : d[35:18];
                p  = {widen(hw[17:12]), widen(hw[11:6]), widen(hw[5:0])};
            end
        end
    endfunction

    task automatic check_dut(input int i);
        int k, hf, vf, n;
        bit w, first;
        logic [18:0] a;
        logic [29:0] p;
        string id;
        id = $sformatf("u%0d", i);
        k  = cfg[i].rd + 2;
        n  = hist.size();
        if (rst) begin
            exp_addr[i] = '0;
            check({id, "_rst_addr"}, 64'(addr_o[i]), 64'd0);
            check({id, "_rst_pix"},  64'(pix_o[i]),  64'(BORDER));
            check({id, "_rst_win"},  64'(win_o[i]),  64'd0);
            check({id, "_rst_fs"},   64'(fs_o[i]),   64'd0);
            return;
        end
        if (n >= 1 && hist[n-1].ok) begin
            fcast(hist[n-1].h, hist[n-1].v, k, hf, vf);
            model(cfg[i], hf, vf, w, first, a, p);
            if (w) exp_addr[i] = a;
        end
        check({id, "_addr"}, 64'(addr_o[i]), 64'(exp_addr[i]));
        w = 1'b0; first = 1'b0; p = BORDER;
        if (n >= k && hist[n-k].ok) begin
            fcast(hist[n-k].h, hist[n-k].v, k, hf, vf);
            model(cfg[i], hf, vf, w, first, a, p);
        end
        check({id, "_pix"}, 64'(pix_o[i]), 64'(p));
        check({id, "_win"}, 64'(win_o[i]), 64'(w));
        check({id, "_fs"},  64'(fs_o[i]),  64'(first));
    endtask

    // Check the current outputs at the falling edge, then present the next inputs.
    task automatic step(input int nh, input int nv, input bit nrst);
        ent_t e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_dut(i);
        if (fs_o[0] === 1'b1) fs_cnt++;
        if (nrst) hist.delete();
        rst    = nrst;
        hcount = 11'(nh);
        vcount = 10'(nv);
        e.h = nh; e.v = nv; e.ok = !nrst;
        hist.push_back(e);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic run(input int h0, input int v0, input int n, output int h_end, output int v_end);
        int h, v;
        h = h0;
        v = v0;
        repeat (n) begin
            step(h, v, 1'b0);
            h++;
            if (h == HT) begin
                h = 0;
                v++;
                if (v == VT) v = 0;
            end
        end
        h_end = h;
        v_end = v;
    endtask

    initial begin
        int he, ve, h, v;
        cfg[0] = '{0, 0, 640, 480, 1, 0, 10, 2};
        cfg[1] = '{100, 20, 320, 200, 2, 1, 10, 3};
        cfg[2] = '{8, 3, 64, 16, 1, 2, 6, 1};
        for (int i = 0; i < 3; i++) exp_addr[i] = '0;

        #2 rst = 1'b1;
        repeat (3) step(0, 0, 1'b1);

        // Line wrap forecast: hcount 1340 on line 10 reads row 11, column 0.
        step(1340, 10, 1'b0);
        @(posedge clk);
        #1 check("wrap_addr", 64'(addr_o[0]), 64'd11264);
        run(1341, 10, 20, he, ve);

        // Left of an offset window: must stay border, no aliasing.
        run(90, 20, 40, he, ve);

        // Asynchronous reset mid-line, then realignment.
        run(250, 30, 50, he, ve);
        step(300, 30, 1'b1);
        #1;
        check("async_addr", 64'(addr_o[0]), 64'd0);
        check("async_pix",  64'(pix_o[0]),  64'(BORDER));
        check("async_win",  64'(win_o[0]),  64'd0);
        step(301, 30, 1'b1);
        step(302, 30, 1'b1);
        run(303, 30, 60, he, ve);

        // Frame wrap: exactly one frame_start for the origin pixel.
        fs_cnt = 0;
        run(1330, 805, 60, he, ve);
        check("fs_count", 64'(fs_cnt), 64'd1);

        // Random raster segments with occasional resets.
        for (int s = 0; s < 40; s++) begin
            h = int'($urandom_range(0, HT - 1));
            v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, VT - 1));
            if ($urandom_range(0, 5) == 0) begin
                repeat (int'($urandom_range(1, 3))) step(h, v, 1'b1);
            end
            run(h, v, int'($urandom_range(20, 200)), he, ve);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
